// File: rtl/rotary_accumulator_if.sv
// Bundle of step/load inputs and value/status outputs for rotary_accumulator.
// The design side uses the slave modport, the driving side the master modport.
interface rotary_accumulator_if #(
    parameter int WIDTH = 8
);
    logic             in_cw;
    logic             in_ccw;
    logic             in_load;
    logic [WIDTH-1:0] in_load_value;
    logic [WIDTH-1:0] out_value;
    logic             out_changed;
    logic             out_at_min;
    logic             out_at_max;

    modport master (
        output in_cw,
        output in_ccw,
        output in_load,
        output in_load_value,
        input  out_value,
        input  out_changed,
        input  out_at_min,
        input  out_at_max
    );

    modport slave (
        input  in_cw,
        input  in_ccw,
        input  in_load,
        input  in_load_value,
        output out_value,
        output out_changed,
        output out_at_min,
        output out_at_max
    );
endinterface

// File: rtl/rotary_accumulator.sv
// Bounded up/down accumulator driven by rotary-encoder step pulses, with
// saturate/wrap modes, clamped parallel load and same-direction acceleration.
module rotary_accumulator #(
    parameter int WIDTH       = 8,
    parameter int MIN_VALUE   = 0,
    parameter int MAX_VALUE   = 255,
    parameter int RESET_VALUE = 0,
    parameter int WRAP        = 0,
    parameter int FAST_WINDOW = 0,
    parameter int FAST_STEP   = 4
) (
    input logic                clk,
    input logic                rst,
    rotary_accumulator_if.slave bus
);

    // Two guard bits keep value+range and value+step free of overflow.
    localparam int EXT  = WIDTH + 2;
    localparam int GAPW = (FAST_WINDOW > 0) ? $clog2(FAST_WINDOW + 1) : 1;

    localparam logic [EXT-1:0]   L_MIN      = EXT'(MIN_VALUE);
    localparam logic [EXT-1:0]   L_MAX      = EXT'(MAX_VALUE);
    localparam logic [EXT-1:0]   L_RANGE    = EXT'(MAX_VALUE - MIN_VALUE + 1);
    localparam logic [EXT-1:0]   L_FAST     = EXT'(FAST_STEP);
    localparam logic [EXT-1:0]   L_ONE      = EXT'(1);
    localparam logic [WIDTH-1:0] L_MIN_W    = WIDTH'(MIN_VALUE);
    localparam logic [WIDTH-1:0] L_MAX_W    = WIDTH'(MAX_VALUE);
    localparam logic [WIDTH-1:0] L_RESET_W  = WIDTH'(RESET_VALUE);
    localparam logic [GAPW-1:0]  L_WIN      = GAPW'(FAST_WINDOW);
    localparam logic [GAPW-1:0]  L_GAP_ONE  = GAPW'(1);
    localparam logic [GAPW-1:0]  L_GAP_ZERO = '0;
    localparam bit               L_ACCEL    = (FAST_WINDOW > 0);
    localparam bit               L_WRAP     = (WRAP != 0);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_ARMED_UP = 2'd1;
    localparam logic [1:0] S_ARMED_DN = 2'd2;

    logic [WIDTH-1:0] r_value;
    logic             r_changed;
    logic [1:0]       r_state;
    logic [GAPW-1:0]  r_gap;

    logic             w_up;
    logic             w_dn;
    logic             w_step;
    logic             w_fast;
    logic [EXT-1:0]   w_cur;
    logic [EXT-1:0]   w_load;
    logic [EXT-1:0]   w_stepSize;
    logic [EXT-1:0]   w_upSum;
    logic [EXT-1:0]   w_dnFloor;
    logic [WIDTH-1:0] w_next;
    logic [1:0]       w_nextState;
    logic [GAPW-1:0]  w_nextGap;

    assign w_up   = bus.in_cw & ~bus.in_ccw;
    assign w_dn   = bus.in_ccw & ~bus.in_cw;
    assign w_step = w_up | w_dn;

    // Fast only when continuing the armed direction inside the window.
    assign w_fast = L_ACCEL && (r_gap != L_WIN) &&
                    (((r_state == S_ARMED_UP) && w_up) ||
                     ((r_state == S_ARMED_DN) && w_dn));

    always_comb begin
        w_cur      = {2'b00, r_value};
        w_load     = {2'b00, bus.in_load_value};
        w_stepSize = w_fast ? L_FAST : L_ONE;
        w_upSum    = w_cur + w_stepSize;
        w_dnFloor  = L_MIN + w_stepSize;
        w_next     = r_value;

        if (bus.in_load) begin
            if (w_load + L_ONE <= L_MIN) begin
                w_next = L_MIN_W;
            end else if (w_load > L_MAX) begin
                w_next = L_MAX_W;
            end else begin
                w_next = bus.in_load_value;
            end
        end else if (w_up) begin
            if (w_upSum > L_MAX) begin
                w_next = L_WRAP ? WIDTH'(w_upSum - L_RANGE) : L_MAX_W;
            end else begin
                w_next = WIDTH'(w_upSum);
            end
        end else if (w_dn) begin
            if (w_cur < w_dnFloor) begin
                w_next = L_WRAP ? WIDTH'(w_cur + L_RANGE - w_stepSize) : L_MIN_W;
            end else begin
                w_next = WIDTH'(w_cur - w_stepSize);
            end
        end
    end

    // Gap counter only advances while armed; hitting the window disarms.
    always_comb begin
        w_nextState = r_state;
        w_nextGap   = r_gap;

        if (bus.in_load) begin
            w_nextState = S_IDLE;
            w_nextGap   = L_GAP_ZERO;
        end else if (w_step) begin
            if (L_ACCEL) begin
                w_nextState = w_up ? S_ARMED_UP : S_ARMED_DN;
            end else begin
                w_nextState = S_IDLE;
            end
            w_nextGap = L_GAP_ZERO;
        end else if (r_state != S_IDLE) begin
            if (r_gap + L_GAP_ONE == L_WIN) begin
                w_nextState = S_IDLE;
                w_nextGap   = L_WIN;
            end else begin
                w_nextGap = r_gap + L_GAP_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_value   <= L_RESET_W;
            r_changed <= 1'b0;
            r_state   <= S_IDLE;
            r_gap     <= L_GAP_ZERO;
        end else begin
            r_value   <= w_next;
            r_changed <= (w_next != r_value);
            r_state   <= w_nextState;
            r_gap     <= w_nextGap;
        end
    end

    assign bus.out_value   = r_value;
    assign bus.out_changed = r_changed;
    assign bus.out_at_min  = (r_value == L_MIN_W);
    assign bus.out_at_max  = (r_value == L_MAX_W);

endmodule

// File: tb/tb_rotary_accumulator.sv
// Directed, table-driven bench for rotary_accumulator over three configurations:
// A = defaults, B = wrapping, C = narrowed range with acceleration.
module tb_rotary_accumulator;

    logic clk = 1'b0;
    logic rstA, rstB, rstC;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    rotary_accumulator_if #(.WIDTH(8)) ifA ();
    rotary_accumulator_if #(.WIDTH(8)) ifB ();
    rotary_accumulator_if #(.WIDTH(8)) ifC ();

    rotary_accumulator #(
        .WIDTH(8), .MIN_VALUE(0), .MAX_VALUE(255), .RESET_VALUE(0),
        .WRAP(0), .FAST_WINDOW(0), .FAST_STEP(4)
    ) dutA (.clk(clk), .rst(rstA), .bus(ifA.slave));

    rotary_accumulator #(
        .WIDTH(8), .MIN_VALUE(0), .MAX_VALUE(255), .RESET_VALUE(0),
        .WRAP(1), .FAST_WINDOW(0), .FAST_STEP(4)
    ) dutB (.clk(clk), .rst(rstB), .bus(ifB.slave));

    rotary_accumulator #(
        .WIDTH(8), .MIN_VALUE(5), .MAX_VALUE(200), .RESET_VALUE(7),
        .WRAP(0), .FAST_WINDOW(5), .FAST_STEP(4)
    ) dutC (.clk(clk), .rst(rstC), .bus(ifC.slave));

    typedef struct {
        int         dut;
        logic       rst;
        logic       cw;
        logic       ccw;
        logic       load;
        logic [7:0] lv;
        int         idle;
        logic [7:0] ev;
        logic       ech;
        logic       emin;
        logic       emax;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int dut, logic rst, logic cw, logic ccw, logic load,
                                logic [7:0] lv, int idle, logic [7:0] ev,
                                logic ech, logic emin, logic emax);
        vec_t v;
        v.dut = dut; v.rst = rst; v.cw = cw; v.ccw = ccw; v.load = load;
        v.lv = lv; v.idle = idle; v.ev = ev; v.ech = ech; v.emin = emin; v.emax = emax;
        return v;
    endfunction

    task automatic driveIdle();
        rstA = 1'b0; rstB = 1'b0; rstC = 1'b0;
        ifA.in_cw = 1'b0; ifA.in_ccw = 1'b0; ifA.in_load = 1'b0; ifA.in_load_value = 8'd0;
        ifB.in_cw = 1'b0; ifB.in_ccw = 1'b0; ifB.in_load = 1'b0; ifB.in_load_value = 8'd0;
        ifC.in_cw = 1'b0; ifC.in_ccw = 1'b0; ifC.in_load = 1'b0; ifC.in_load_value = 8'd0;
    endtask

    task automatic setInputs(input vec_t v);
        driveIdle();
        case (v.dut)
            0: begin
                rstA = v.rst; ifA.in_cw = v.cw; ifA.in_ccw = v.ccw;
                ifA.in_load = v.load; ifA.in_load_value = v.lv;
            end
            1: begin
                rstB = v.rst; ifB.in_cw = v.cw; ifB.in_ccw = v.ccw;
                ifB.in_load = v.load; ifB.in_load_value = v.lv;
            end
            default: begin
                rstC = v.rst; ifC.in_cw = v.cw; ifC.in_ccw = v.ccw;
                ifC.in_load = v.load; ifC.in_load_value = v.lv;
            end
        endcase
    endtask

    task automatic readOutputs(input int dut, output logic [7:0] val, output logic ch,
                               output logic mn, output logic mx);
        case (dut)
            0:       begin val = ifA.out_value; ch = ifA.out_changed; mn = ifA.out_at_min; mx = ifA.out_at_max; end
            1:       begin val = ifB.out_value; ch = ifB.out_changed; mn = ifB.out_at_min; mx = ifB.out_at_max; end
            default: begin val = ifC.out_value; ch = ifC.out_changed; mn = ifC.out_at_min; mx = ifC.out_at_max; end
        endcase
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic checkAll(input string tag, input int dut, input logic [7:0] ev,
                            input logic ech, input logic emin, input logic emax);
        logic [7:0] val;
        logic ch, mn, mx;
        readOutputs(dut, val, ch, mn, mx);
        checkOutput({tag, ".value"},   {24'd0, val}, {24'd0, ev});
        checkOutput({tag, ".changed"}, {31'd0, ch},  {31'd0, ech});
        checkOutput({tag, ".at_min"},  {31'd0, mn},  {31'd0, emin});
        checkOutput({tag, ".at_max"},  {31'd0, mx},  {31'd0, emax});
    endtask

    // Apply one vector on a single edge, check one cycle later, then idle.
    task automatic applyStimulus(input vec_t v, input int idx);
        @(negedge clk);
        setInputs(v);
        @(posedge clk);
        #1;
        checkAll($sformatf("vec%0d", idx), v.dut, v.ev, v.ech, v.emin, v.emax);
        repeat (v.idle) begin
            @(negedge clk);
            driveIdle();
            @(posedge clk);
        end
    endtask

    initial begin
        driveIdle();
        rstA = 1'b1; rstB = 1'b1; rstC = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        driveIdle();

        // A: defaults, saturating, no acceleration
        vecs.push_back(mk(0, 1, 1, 0, 0,   0, 9,   0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0,   0, 9,   1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0,   0, 9,   2, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0,   0, 1,   3, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 254, 1, 254, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0,   0, 1, 255, 1, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0,   0, 1, 255, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0,   0, 1, 255, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 1,  50, 1,  50, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0,   0, 1,  50, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1,  50, 1,  50, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0,   0, 1,  49, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1,   0, 1,   0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0,   0, 1,   0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0,   0, 0,   1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0,   0, 1,   2, 1, 0, 0));
        // B: wrapping across both ends
        vecs.push_back(mk(1, 1, 0, 1, 0,   0, 1,   0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1,   1, 1,   1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0,   0, 1,   0, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0,   0, 1, 255, 1, 0, 1));
        vecs.push_back(mk(1, 0, 0, 1, 0,   0, 1, 254, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 255, 1, 255, 1, 0, 1));
        vecs.push_back(mk(1, 0, 1, 0, 0,   0, 1,   0, 1, 1, 0));
        // C: range 5..200, reset 7, window 5, fast step 4
        vecs.push_back(mk(2, 1, 1, 0, 0,   0, 1,   7, 0, 0, 0));
        vecs.push_back(mk(2, 0, 0, 0, 1,  10, 1,  10, 1, 0, 0));
        vecs.push_back(mk(2, 0, 1, 0, 0,   0, 2,  11, 1, 0, 0));
        vecs.push_back(mk(2, 0, 1, 0, 0,   0, 2,  15, 1, 0, 0));
        vecs.push_back(mk(2, 0, 1, 0, 0,   0, 13, 19, 1, 0, 0));
        vecs.push_back(mk(2, 0, 1, 0, 0,   0, 1,  20, 1, 0, 0));
        vecs.push_back(mk(2, 0, 0, 1, 0,   0, 1,  19, 1, 0, 0));
        vecs.push_back(mk(2, 0, 0, 1, 0,   0, 4,  15, 1, 0, 0));
        vecs.push_back(mk(2, 0, 0, 1, 0,   0, 5,  11, 1, 0, 0));
        vecs.push_back(mk(2, 0, 0, 1, 0,   0, 1,  10, 1, 0, 0));
        vecs.push_back(mk(2, 0, 1, 0, 0,   0, 1,  11, 1, 0, 0));
        vecs.push_back(mk(2, 0, 1, 0, 0,   0, 0,  15, 1, 0, 0));
        vecs.push_back(mk(2, 1, 1, 0, 0,   0, 1,   7, 0, 0, 0));
        vecs.push_back(mk(2, 0, 1, 0, 0,   0, 1,   8, 1, 0, 0));
        vecs.push_back(mk(2, 0, 0, 0, 1,   2, 1,   5, 1, 1, 0));
        vecs.push_back(mk(2, 0, 0, 1, 0,   0, 1,   5, 0, 1, 0));
        vecs.push_back(mk(2, 0, 0, 0, 1, 250, 1, 200, 1, 0, 1));
        vecs.push_back(mk(2, 0, 0, 0, 1, 198, 1, 198, 1, 0, 0));
        vecs.push_back(mk(2, 0, 1, 0, 0,   0, 0, 199, 1, 0, 0));
        vecs.push_back(mk(2, 0, 1, 0, 0,   0, 0, 200, 1, 0, 1));
        vecs.push_back(mk(2, 0, 1, 0, 0,   0, 1, 200, 0, 0, 1));

        foreach (vecs[i]) applyStimulus(vecs[i], i);

        // out_changed must be a single-cycle pulse and the value must hold.
        applyStimulus(mk(0, 0, 1, 0, 0, 0, 0, 3, 1, 0, 0), 1000);
        @(negedge clk);
        driveIdle();
        @(posedge clk);
        #1;
        checkAll("pulse.after1", 0, 8'd3, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(posedge clk);
        #1;
        checkAll("pulse.after2", 0, 8'd3, 1'b0, 1'b0, 1'b0);

        // Reset held over several cycles with steps present keeps the reset value.
        @(negedge clk);
        driveIdle();
        rstC = 1'b1;
        ifC.in_cw = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkAll("rsthold", 2, 8'd7, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        driveIdle();
        ifC.in_ccw = 1'b1;
        @(posedge clk);
        #1;
        checkAll("rsthold.step", 2, 8'd6, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        driveIdle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
